// File: rtl/instr_control_fsm.sv
// Instruction register, decoder and control FSM for the datapath.
// Captures a 16-bit instruction on load (only while idle), then sequences
// the register-fetch / ALU / status / writeback strobes for a small ISA
// subset: MOV imm, MOV reg, MVN, ADD, CMP, AND. Other encodings are
// decoded and dropped without touching the datapath.
module instr_control_fsm #(
    parameter logic [15:0] IR_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic [1:0]  shift,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  ALUop,
    output logic        loadc,
    output logic        loads,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    localparam logic [2:0] S_WAIT      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_WRITE_IMM = 3'd2;
    localparam logic [2:0] S_GET_A     = 3'd3;
    localparam logic [2:0] S_GET_B     = 3'd4;
    localparam logic [2:0] S_COMPUTE   = 3'd5;
    localparam logic [2:0] S_WRITE_REG = 3'd6;

    // {opcode, op} encodings of the supported instructions
    localparam logic [4:0] I_MOV_IMM = 5'b110_10;
    localparam logic [4:0] I_MOV_REG = 5'b110_00;
    localparam logic [4:0] I_MVN     = 5'b101_11;
    localparam logic [4:0] I_ADD     = 5'b101_00;
    localparam logic [4:0] I_CMP     = 5'b101_01;
    localparam logic [4:0] I_AND     = 5'b101_10;

    logic [2:0]  state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [4:0] opc_op;
    logic [1:0] op;
    logic [2:0] rn, rd, rm;
    logic [1:0] sh;
    logic       is_movreg, is_mvn, is_cmp;

    assign opc_op    = ir_q[15:11];
    assign op        = ir_q[12:11];
    assign rn        = ir_q[10:8];
    assign rd        = ir_q[7:5];
    assign sh        = ir_q[4:3];
    assign rm        = ir_q[2:0];
    assign is_movreg = (opc_op == I_MOV_REG);
    assign is_mvn    = (opc_op == I_MVN);
    assign is_cmp    = (opc_op == I_CMP);

    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
    assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

    // IR captures only while idle, so load during execution cannot corrupt the decode
    always_comb begin
        ir_d = ir_q;
        if (state_q == S_WAIT && load) begin
            ir_d = in;
        end
    end

    // Next-state logic; s is only looked at in WAIT, so it is never queued
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (s) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opc_op)
                    I_MOV_IMM:                 state_d = S_WRITE_IMM;
                    I_MOV_REG, I_MVN:          state_d = S_GET_B;
                    I_ADD, I_CMP, I_AND:       state_d = S_GET_A;
                    default:                   state_d = S_WAIT;
                endcase
            end
            S_WRITE_IMM: state_d = S_WAIT;
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_COMPUTE;
            S_COMPUTE:   state_d = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    // State and instruction registers; reset abandons any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= IR_RESET;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Moore outputs decoded from the current state and the latched instruction
    always_comb begin
        w        = 1'b0;
        readnum  = 3'b000;
        writenum = 3'b000;
        write    = 1'b0;
        vsel     = 2'b00;
        loada    = 1'b0;
        loadb    = 1'b0;
        shift    = 2'b00;
        asel     = 1'b0;
        bsel     = 1'b0;
        ALUop    = 2'b00;
        loadc    = 1'b0;
        loads    = 1'b0;
        case (state_q)
            S_WAIT: begin
                w = 1'b1;
            end
            S_WRITE_IMM: begin
                write    = 1'b1;
                vsel     = 2'b10;
                writenum = rn;
            end
            S_GET_A: begin
                loada   = 1'b1;
                readnum = rn;
            end
            S_GET_B: begin
                loadb   = 1'b1;
                readnum = rm;
                shift   = sh;
            end
            S_COMPUTE: begin
                shift = sh;
                asel  = is_movreg | is_mvn;
                ALUop = is_movreg ? 2'b00 : op;
                loads = is_cmp;
                loadc = ~is_cmp;
            end
            S_WRITE_REG: begin
                write    = 1'b1;
                vsel     = 2'b00;
                writenum = rd;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_instr_control_fsm.sv
// Directed self-checking bench for instr_control_fsm.
// Outputs are packed into one observation vector and compared cycle by
// cycle against hand-written expected vectors, sampled 1 ns after each
// rising clock edge.
module tb_instr_control_fsm;

    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    int checks = 0;
    int errors = 0;

    instr_control_fsm #(.IR_RESET(16'h0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .load     (load),
        .s        (s),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .shift    (shift),
        .asel     (asel),
        .bsel     (bsel),
        .ALUop    (ALUop),
        .loadc    (loadc),
        .loads    (loads),
        .sximm8   (sximm8),
        .sximm5   (sximm5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {w, write, loada, loadb, loadc, loads, asel, bsel, vsel, ALUop, shift, readnum, writenum}
    logic [19:0] obs;
    assign obs = {w, write, loada, loadb, loadc, loads, asel, bsel,
                  vsel, ALUop, shift, readnum, writenum};

    function automatic logic [19:0] ev(input logic ww, wr, la, lb, lc, ls, as,
                                       input logic [1:0] vs, alu, sh,
                                       input logic [2:0] rn, wn);
        return {ww, wr, la, lb, lc, ls, as, 1'b0, vs, alu, sh, rn, wn};
    endfunction

    localparam logic [19:0] IDLE = 20'h80000;  // w=1, everything else 0
    localparam logic [19:0] BUSY = 20'h00000;  // DECODE: w=0, no strobes

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction with load and s for one edge; returns in DECODE.
    task automatic start(input logic [15:0] instr);
        in   = instr;
        load = 1'b1;
        s    = 1'b1;
        tick();
        load = 1'b0;
        s    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in    = 16'hFFFF;
        load  = 1'b0;
        s     = 1'b0;
        tick();
        tick();
        checks++;
        if (obs !== IDLE) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, IDLE);
        end
        checks++;
        if (sximm8 !== 16'h0000 || sximm5 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_ir: got sximm8=%h sximm5=%h expected 0000/0000", sximm8, sximm5);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (obs !== IDLE) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", obs, IDLE);
        end
    endtask

    task automatic test_mov_imm(input logic [15:0] instr, input logic [2:0] rn,
                                input logic [15:0] imm8, input logic [15:0] imm5);
        logic [19:0] e [0:2];
        e = '{BUSY, ev(0,1,0,0,0,0,0,2'b10,2'b00,2'b00,3'd0,rn), IDLE};
        start(instr);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL mov_imm_%h c%0d: got %h expected %h", instr, i + 1, obs, e[i]);
            end
        end
        checks++;
        if (sximm8 !== imm8 || sximm5 !== imm5) begin
            errors++;
            $display("FAIL mov_imm_%h sximm: got %h/%h expected %h/%h", instr, sximm8, sximm5, imm8, imm5);
        end
    endtask

    task automatic test_add();
        logic [19:0] e [0:5];
        // ADD R2,R1,R0,LSL#1
        e = '{BUSY,
              ev(0,0,1,0,0,0,0,2'b00,2'b00,2'b00,3'd1,3'd0),
              ev(0,0,0,1,0,0,0,2'b00,2'b00,2'b01,3'd0,3'd0),
              ev(0,0,0,0,1,0,0,2'b00,2'b00,2'b01,3'd0,3'd0),
              ev(0,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd2),
              IDLE};
        start(16'hA148);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL add c%0d: got %h expected %h", i + 1, obs, e[i]);
            end
        end
    endtask

    task automatic test_cmp_and_busy_s();
        logic [19:0] e [0:5];
        // CMP R0,R1; s pulsed while busy must not start a new instruction
        e = '{BUSY,
              ev(0,0,1,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0),
              ev(0,0,0,1,0,0,0,2'b00,2'b00,2'b00,3'd1,3'd0),
              ev(0,0,0,0,0,1,0,2'b00,2'b01,2'b00,3'd0,3'd0),
              IDLE, IDLE};
        start(16'hA801);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            s = (i == 1 || i == 2);
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL cmp c%0d: got %h expected %h", i + 1, obs, e[i]);
            end
        end
        s = 1'b0;
    endtask

    task automatic test_mvn_movreg_and();
        logic [15:0] instr [0:2];
        int          len   [0:2];
        logic [19:0] e     [0:2][0:5];
        instr = '{16'hB8E2, 16'hC05B, 16'hB2A9};
        len   = '{5, 5, 6};
        // MVN R7,R2
        e[0] = '{BUSY,
                 ev(0,0,0,1,0,0,0,2'b00,2'b00,2'b00,3'd2,3'd0),
                 ev(0,0,0,0,1,0,1,2'b00,2'b11,2'b00,3'd0,3'd0),
                 ev(0,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd7),
                 IDLE, IDLE};
        // MOV R2,R3,ASR
        e[1] = '{BUSY,
                 ev(0,0,0,1,0,0,0,2'b00,2'b00,2'b11,3'd3,3'd0),
                 ev(0,0,0,0,1,0,1,2'b00,2'b00,2'b11,3'd0,3'd0),
                 ev(0,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd2),
                 IDLE, IDLE};
        // AND R5,R2,R1,LSL#1
        e[2] = '{BUSY,
                 ev(0,0,1,0,0,0,0,2'b00,2'b00,2'b00,3'd2,3'd0),
                 ev(0,0,0,1,0,0,0,2'b00,2'b00,2'b01,3'd1,3'd0),
                 ev(0,0,0,0,1,0,0,2'b00,2'b10,2'b01,3'd0,3'd0),
                 ev(0,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd5),
                 IDLE};
        for (int k = 0; k < 3; k++) begin
            start(instr[k]);
            for (int i = 0; i < len[k]; i++) begin
                if (i > 0) tick();
                checks++;
                if (obs !== e[k][i]) begin
                    errors++;
                    $display("FAIL op_%h c%0d: got %h expected %h", instr[k], i + 1, obs, e[k][i]);
                end
            end
        end
    endtask

    task automatic test_undefined();
        logic [19:0] e [0:2];
        e = '{BUSY, IDLE, IDLE};
        start(16'hE000);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL undefined c%0d: got %h expected %h", i + 1, obs, e[i]);
            end
        end
    endtask

    task automatic test_load_while_busy();
        logic [19:0] e [0:5];
        e = '{BUSY,
              ev(0,0,1,0,0,0,0,2'b00,2'b00,2'b00,3'd1,3'd0),
              ev(0,0,0,1,0,0,0,2'b00,2'b00,2'b01,3'd0,3'd0),
              ev(0,0,0,0,1,0,0,2'b00,2'b00,2'b01,3'd0,3'd0),
              ev(0,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd2),
              IDLE};
        start(16'hA148);
        in   = 16'hD1FE;
        load = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            checks++;
            if (obs !== e[i] || sximm8 !== 16'h0048) begin
                errors++;
                $display("FAIL load_busy c%0d: got %h sximm8=%h expected %h sximm8=0048",
                         i + 1, obs, sximm8, e[i]);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [19:0] e [0:5];
        e = '{BUSY, ev(0,1,0,0,0,0,0,2'b10,2'b00,2'b00,3'd0,3'd1), IDLE,
              BUSY, ev(0,1,0,0,0,0,0,2'b10,2'b00,2'b00,3'd0,3'd1), IDLE};
        in   = 16'hD1FE;
        load = 1'b1;
        s    = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            if (i == 4) s = 1'b0;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL back_to_back c%0d: got %h expected %h", i + 1, obs, e[i]);
            end
        end
        s = 1'b0;
    endtask

    task automatic test_reset_mid_instr();
        logic [19:0] getb;
        getb = ev(0,0,0,1,0,0,0,2'b00,2'b00,2'b01,3'd0,3'd0);
        start(16'hA148);
        tick();
        tick();
        checks++;
        if (obs !== getb) begin
            errors++;
            $display("FAIL reset_mid_getb: got %h expected %h", obs, getb);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (obs !== IDLE || sximm8 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_async: got %h sximm8=%h expected %h sximm8=0000", obs, sximm8, IDLE);
        end
        #2 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (obs !== IDLE) begin
                errors++;
                $display("FAIL reset_mid_after c%0d: got %h expected %h", i + 1, obs, IDLE);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mov_imm(16'hD007, 3'd0, 16'h0007, 16'h0007);
        test_mov_imm(16'hD1FE, 3'd1, 16'hFFFE, 16'hFFFE);
        test_add();
        test_cmp_and_busy_s();
        test_mvn_movreg_and();
        test_undefined();
        test_load_while_busy();
        test_back_to_back();
        test_reset_mid_instr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
